// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU operation codes, ID/EX entry
// layout and the forwarding match rule used by the operand bypass logic.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;
  localparam int REG_AW = 5;

  localparam logic [CTRL_W-1:0] ALU_AND = 4'd0;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'd1;
  localparam logic [CTRL_W-1:0] ALU_ADD = 4'd2;
  localparam logic [CTRL_W-1:0] ALU_MUL = 4'd3;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'd6;
  localparam logic [CTRL_W-1:0] ALU_SLT = 4'd7;
  localparam logic [CTRL_W-1:0] ALU_NOR = 4'd12;

  // Occupancy of the two-entry elastic buffer.
  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_TWO   = 2'd2
  } cnt_e;

  // One buffered instruction; op2_data holds either rt data or the immediate.
  typedef struct packed {
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] op2_data;
    logic              op2_is_imm;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              reg_write;
  } id_ex_entry_t;

  // A producer supplies an operand when it writes a non-zero register equal to the operand's source.
  function automatic logic fwd_hit(input logic wr, input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] addr);
    return wr & (rd != 5'd0) & (rd == addr);
  endfunction

endpackage

// File: rtl/operand_fwd.sv
// Bypass select for a single operand: EX/MEM result first, then MEM/WB data,
// otherwise the stored value. Immediate operands pass through untouched.
module operand_fwd
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              no_fwd_i,
  input  logic              exmem_wr_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic              memwb_wr_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [DATA_W-1:0] data_o
);

  // Pick the youngest producer that targets this operand's source register.
  always_comb begin
    data_o = data_i;
    if (no_fwd_i) begin
      data_o = data_i;
    end else if (fwd_hit(exmem_wr_i, exmem_rd_i, addr_i)) begin
      data_o = exmem_data_i;
    end else if (fwd_hit(memwb_wr_i, memwb_rd_i, addr_i)) begin
      data_o = memwb_data_i;
    end else begin
      data_o = data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: two-entry elastic buffer (main = head, skid = second)
// between decode and the ALU, with operand forwarding on the head and a
// per-cycle refresh of held entries so stalled operands track producers.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              alu_src_i,
  input  logic [CTRL_W-1:0] alu_ctrl_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              reg_write_i,
  input  logic              flush_i,
  input  logic              exmem_wr_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic              memwb_wr_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] src1_o,
  output logic [DATA_W-1:0] src2_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              reg_write_o
);

  cnt_e         state_q, state_d;
  id_ex_entry_t main_q, main_d;
  id_ex_entry_t skid_q, skid_d;
  logic         in_ready_q;

  id_ex_entry_t new_entry_s;
  id_ex_entry_t main_ref_s;
  id_ex_entry_t skid_ref_s;
  logic [DATA_W-1:0] main_rs_fwd_s, main_op2_fwd_s;
  logic [DATA_W-1:0] skid_rs_fwd_s, skid_op2_fwd_s;
  logic push_s, pop_s;

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != CNT_EMPTY);
  assign push_s      = in_valid_i & in_ready_q;
  assign pop_s       = (state_q != CNT_EMPTY) & out_ready_i;

  // Head operands: these feed both the ALU view and the head's own refresh.
  operand_fwd u_fwd_main_rs (
    .addr_i(main_q.rs_addr), .data_i(main_q.rs_data), .no_fwd_i(1'b0),
    .exmem_wr_i(exmem_wr_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
    .memwb_wr_i(memwb_wr_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .data_o(main_rs_fwd_s)
  );
  operand_fwd u_fwd_main_op2 (
    .addr_i(main_q.rt_addr), .data_i(main_q.op2_data), .no_fwd_i(main_q.op2_is_imm),
    .exmem_wr_i(exmem_wr_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
    .memwb_wr_i(memwb_wr_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .data_o(main_op2_fwd_s)
  );
  // Skid operands: refreshed while waiting behind the head.
  operand_fwd u_fwd_skid_rs (
    .addr_i(skid_q.rs_addr), .data_i(skid_q.rs_data), .no_fwd_i(1'b0),
    .exmem_wr_i(exmem_wr_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
    .memwb_wr_i(memwb_wr_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .data_o(skid_rs_fwd_s)
  );
  operand_fwd u_fwd_skid_op2 (
    .addr_i(skid_q.rt_addr), .data_i(skid_q.op2_data), .no_fwd_i(skid_q.op2_is_imm),
    .exmem_wr_i(exmem_wr_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
    .memwb_wr_i(memwb_wr_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .data_o(skid_op2_fwd_s)
  );

  // Assemble the incoming entry and the refreshed copies of both held entries.
  always_comb begin
    new_entry_s            = '0;
    new_entry_s.rs_addr    = rs_addr_i;
    new_entry_s.rt_addr    = rt_addr_i;
    new_entry_s.rd_addr    = rd_addr_i;
    new_entry_s.rs_data    = rs_data_i;
    new_entry_s.op2_data   = alu_src_i ? imm_i : rt_data_i;
    new_entry_s.op2_is_imm = alu_src_i;
    new_entry_s.alu_ctrl   = alu_ctrl_i;
    new_entry_s.reg_write  = reg_write_i;

    main_ref_s          = main_q;
    main_ref_s.rs_data  = main_rs_fwd_s;
    main_ref_s.op2_data = main_op2_fwd_s;
    skid_ref_s          = skid_q;
    skid_ref_s.rs_data  = skid_rs_fwd_s;
    skid_ref_s.op2_data = skid_op2_fwd_s;
  end

  // Occupancy transitions; flush empties the buffer and drops any incoming entry.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = CNT_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        CNT_EMPTY: begin
          if (push_s) begin
            state_d = CNT_ONE;
            main_d  = new_entry_s;
          end else begin
            state_d = CNT_EMPTY;
          end
        end
        CNT_ONE: begin
          case ({push_s, pop_s})
            2'b10: begin
              state_d = CNT_TWO;
              main_d  = main_ref_s;
              skid_d  = new_entry_s;
            end
            2'b01: begin
              state_d = CNT_EMPTY;
              main_d  = '0;
            end
            2'b11: begin
              state_d = CNT_ONE;
              main_d  = new_entry_s;
            end
            default: begin
              state_d = CNT_ONE;
              main_d  = main_ref_s;
            end
          endcase
        end
        CNT_TWO: begin
          if (pop_s) begin
            state_d = CNT_ONE;
            main_d  = skid_ref_s;
            skid_d  = '0;
          end else begin
            state_d = CNT_TWO;
            main_d  = main_ref_s;
            skid_d  = skid_ref_s;
          end
        end
        default: begin
          state_d = CNT_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // Buffer state and the registered ready flag, which stays low through reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CNT_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != CNT_TWO);
    end
  end

  // ALU view of the head; all fields read as zero while nothing is valid.
  always_comb begin
    src1_o      = '0;
    src2_o      = '0;
    alu_ctrl_o  = '0;
    rd_addr_o   = '0;
    reg_write_o = 1'b0;
    if (out_valid_o) begin
      src1_o      = main_rs_fwd_s;
      src2_o      = main_op2_fwd_s;
      alu_ctrl_o  = main_q.alu_ctrl;
      rd_addr_o   = main_q.rd_addr;
      reg_write_o = main_q.reg_write;
    end else begin
      src1_o      = '0;
      src2_o      = '0;
      alu_ctrl_o  = '0;
      rd_addr_o   = '0;
      reg_write_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage. Stimulus drives shortly after
// each rising edge and queues accepted instructions; a monitor on the falling
// edge models buffer contents as a FIFO of operand values, checks the head
// view, ready/valid flags, and applies producer writes to held entries.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, in_valid_i, in_ready_o, alu_src_i, reg_write_i, flush_i;
  logic [31:0] rs_data_i, rt_data_i, imm_i, exmem_data_i, memwb_data_i;
  logic [3:0]  alu_ctrl_i, alu_ctrl_o;
  logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i, exmem_rd_i, memwb_rd_i, rd_addr_o;
  logic        exmem_wr_i, memwb_wr_i, out_valid_o, out_ready_i, reg_write_o;
  logic [31:0] src1_o, src2_o;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i), .alu_src_i(alu_src_i),
    .alu_ctrl_i(alu_ctrl_i), .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .rd_addr_i(rd_addr_i), .reg_write_i(reg_write_i), .flush_i(flush_i),
    .exmem_wr_i(exmem_wr_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
    .memwb_wr_i(memwb_wr_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .src1_o(src1_o),
    .src2_o(src2_o), .alu_ctrl_o(alu_ctrl_o), .rd_addr_o(rd_addr_o),
    .reg_write_o(reg_write_o)
  );

  typedef struct {
    int          stamp;
    logic [4:0]  rs, rt, rd;
    logic [31:0] v1, v2;
    bit          imm;
    logic [3:0]  ctrl;
    bit          wr;
  } mentry_t;

  mentry_t q[$];
  int      vectors = 0;
  int      miscompares = 0;
  int      cyc = 0;
  int      pops = 0;
  int      n_old;
  bit      prev_rst = 1'b1;
  mentry_t hd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Value an operand sourced from register a should take given this cycle's producers.
  function automatic logic [31:0] fwd_val(input logic [4:0] a, input logic [31:0] v);
    if (a != 5'd0 && exmem_wr_i && exmem_rd_i == a) return exmem_data_i;
    if (a != 5'd0 && memwb_wr_i && memwb_rd_i == a) return memwb_data_i;
    return v;
  endfunction

  function automatic logic [4:0] pick_addr();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd8;
      2: return 5'd9;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    n_old = 0;
    foreach (q[i]) if (q[i].stamp < cyc) n_old++;
    chk("in_ready", {31'd0, in_ready_o}, prev_rst ? 32'd0 : {31'd0, n_old < 2});
    chk("out_valid", {31'd0, out_valid_o}, {31'd0, n_old > 0});
    if (n_old > 0) begin
      hd = q[0];
      chk("src1", src1_o, fwd_val(hd.rs, hd.v1));
      chk("src2", src2_o, hd.imm ? hd.v2 : fwd_val(hd.rt, hd.v2));
      chk("ctrl", {28'd0, alu_ctrl_o}, {28'd0, hd.ctrl});
      chk("rd_wr", {26'd0, rd_addr_o, reg_write_o}, {26'd0, hd.rd, hd.wr});
    end else begin
      chk("idle_zero", src1_o | src2_o | {28'd0, alu_ctrl_o} | {27'd0, rd_addr_o}
                       | {31'd0, reg_write_o}, 32'd0);
    end
    if (rst_i || flush_i) begin
      q.delete();
    end else begin
      if (n_old > 0 && out_ready_i) begin
        void'(q.pop_front());
        pops++;
      end
      foreach (q[i]) begin
        if (q[i].stamp < cyc) begin
          q[i].v1 = fwd_val(q[i].rs, q[i].v1);
          if (!q[i].imm) q[i].v2 = fwd_val(q[i].rt, q[i].v2);
        end
      end
    end
    prev_rst = rst_i;
  end

  // Stimulus.
  initial begin
    mentry_t e;
    int      phase;
    rst_i = 1'b1; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    rs_data_i = 32'd0; rt_data_i = 32'd0; imm_i = 32'd0; alu_src_i = 1'b0;
    alu_ctrl_i = 4'd0; rs_addr_i = 5'd0; rt_addr_i = 5'd0; rd_addr_i = 5'd0;
    reg_write_i = 1'b0; exmem_wr_i = 1'b0; exmem_rd_i = 5'd0; exmem_data_i = 32'd0;
    memwb_wr_i = 1'b0; memwb_rd_i = 5'd0; memwb_data_i = 32'd0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      phase       = c / 300;
      rst_i       = (c < 2) || (c >= 2000 && c < 2003);
      in_valid_i  = ($urandom_range(0, 3) != 0);
      case (phase % 3)
        0: out_ready_i = ($urandom_range(0, 7) == 0);
        1: out_ready_i = 1'b1;
        default: out_ready_i = 1'($urandom_range(0, 1));
      endcase
      flush_i      = ($urandom_range(0, 49) == 0);
      rs_data_i    = $urandom;
      rt_data_i    = $urandom;
      imm_i        = $urandom;
      alu_src_i    = ($urandom_range(0, 3) == 0);
      alu_ctrl_i   = 4'($urandom_range(0, 15));
      rs_addr_i    = pick_addr();
      rt_addr_i    = pick_addr();
      rd_addr_i    = pick_addr();
      reg_write_i  = 1'($urandom_range(0, 1));
      exmem_wr_i   = ($urandom_range(0, 2) == 0);
      exmem_rd_i   = pick_addr();
      exmem_data_i = $urandom;
      memwb_wr_i   = ($urandom_range(0, 2) == 0);
      memwb_rd_i   = pick_addr();
      memwb_data_i = $urandom;
      if (in_valid_i && in_ready_o) begin
        e.stamp = cyc;
        e.rs    = rs_addr_i;
        e.rt    = rt_addr_i;
        e.rd    = rd_addr_i;
        e.v1    = rs_data_i;
        e.v2    = alu_src_i ? imm_i : rt_data_i;
        e.imm   = alu_src_i;
        e.ctrl  = alu_ctrl_i;
        e.wr    = reg_write_i;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    @(negedge clk);
    #1;
    chk("pops_seen", {31'd0, pops > 200}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
